// File: rtl/ipsum_noc_pkg.sv
// ipsum_noc_pkg
// Shared types and constants for the ipsum NoC transmit controller:
//   state_t    - controller FSM states (IDLE, RUN, FLUSH, DONE)
//   PACK_DEF   - default number of 16-bit lanes per GON word
//   LANE_CNT_W - width of a counter that can hold 0..PACK_DEF
package ipsum_noc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PACK_DEF   = 4;
    localparam int LANE_CNT_W = $clog2(PACK_DEF + 1);

endpackage

// File: rtl/ipsum_noc_controller_psum_packer.sv
// psum_packer
// Lane accumulator plus output register for the ipsum transmit path.
// A read issued in cycle k lands its data in lane r_fill in cycle k+1.
// A packet is sealed once all of its reads are issued (PACK lanes, or the
// last element of a row). When the sealed packet has fully landed it moves
// into the output register, which drains into the GON FIFO when not full.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   i_issue             a read is being issued this cycle
//   i_last_in_row       the issued read is the last element of its row
//   i_row_tag/i_col_tag tags of the issued read's packet
//   i_din               read data landing this cycle (valid when a read is inflight)
//   i_full              GON FIFO back-pressure
//   o_can_issue         a read issued now has a lane to land in
//   o_drained           nothing left after this cycle (no lanes, inflight or output)
//   o_we, o_dout, o_row_tag, o_col_tag   GON FIFO write interface
module psum_packer
    import ipsum_noc_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int PACK          = PACK_DEF,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_issue,
    input  logic                          i_last_in_row,
    input  logic [ROW_TAG_WIDTH-1:0]      i_row_tag,
    input  logic [COL_TAG_WIDTH-1:0]      i_col_tag,
    input  logic [DATA_WIDTH-1:0]         i_din,
    input  logic                          i_full,
    output logic                          o_can_issue,
    output logic                          o_drained,
    output logic                          o_we,
    output logic [PACK*DATA_WIDTH-1:0]    o_dout,
    output logic [ROW_TAG_WIDTH-1:0]      o_row_tag,
    output logic [COL_TAG_WIDTH-1:0]      o_col_tag
);

    localparam int CNT_W = $clog2(PACK + 1);
    localparam int GW    = PACK * DATA_WIDTH;

    logic                     r_infl;
    logic [CNT_W-1:0]         r_fill;
    logic [CNT_W-1:0]         r_issued;
    logic                     r_seal;
    logic [GW-1:0]            r_lanes;
    logic [ROW_TAG_WIDTH-1:0] r_row;
    logic [COL_TAG_WIDTH-1:0] r_col;
    logic [GW-1:0]            r_out_data;
    logic [ROW_TAG_WIDTH-1:0] r_out_row;
    logic [COL_TAG_WIDTH-1:0] r_out_col;
    logic                     r_out_valid;

    logic                     w_we;
    logic                     w_xfer;
    logic [CNT_W-1:0]         w_issued_nxt;
    logic [GW-1:0]            w_merged;

    assign w_we   = r_out_valid & ~i_full;
    // A sealed packet moves out once its final lane lands (or already has)
    // and the output register is free or draining this cycle.
    assign w_xfer = r_seal & (~r_out_valid | w_we);
    // Stop reading while the output register is stalled, so a held FIFO
    // full costs at most one packet of reads plus one.
    assign o_can_issue  = (~r_seal | w_xfer) & ~(r_out_valid & i_full);
    assign o_drained    = ~r_infl & (r_fill == CNT_W'(0)) & ~r_seal & (~r_out_valid | w_we);
    assign w_issued_nxt = (w_xfer ? CNT_W'(0) : r_issued) + CNT_W'(1);

    assign o_we      = w_we;
    assign o_dout    = r_out_data;
    assign o_row_tag = r_out_row;
    assign o_col_tag = r_out_col;

    // Lane image including the word landing this cycle.
    always_comb begin
        w_merged = r_lanes;
        for (int i = 0; i < PACK; i++) begin
            if (r_infl && (r_fill == CNT_W'(i))) begin
                w_merged[i*DATA_WIDTH +: DATA_WIDTH] = i_din;
            end else begin
                w_merged[i*DATA_WIDTH +: DATA_WIDTH] = r_lanes[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Accumulator, seal tracking and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_infl      <= 1'b0;
            r_fill      <= CNT_W'(0);
            r_issued    <= CNT_W'(0);
            r_seal      <= 1'b0;
            r_lanes     <= GW'(0);
            r_row       <= ROW_TAG_WIDTH'(0);
            r_col       <= COL_TAG_WIDTH'(0);
            r_out_data  <= GW'(0);
            r_out_row   <= ROW_TAG_WIDTH'(0);
            r_out_col   <= COL_TAG_WIDTH'(0);
            r_out_valid <= 1'b0;
        end else begin
            r_infl <= i_issue;
            if (w_xfer) begin
                // Cleared lanes give the zero padding of short packets.
                r_out_data  <= w_merged;
                r_out_row   <= r_row;
                r_out_col   <= r_col;
                r_out_valid <= 1'b1;
                r_lanes     <= GW'(0);
                r_fill      <= CNT_W'(0);
                r_issued    <= CNT_W'(0);
                r_seal      <= 1'b0;
            end else begin
                if (r_infl) begin
                    r_lanes <= w_merged;
                    r_fill  <= r_fill + CNT_W'(1);
                end
                if (w_we) begin
                    r_out_data  <= GW'(0);
                    r_out_row   <= ROW_TAG_WIDTH'(0);
                    r_out_col   <= COL_TAG_WIDTH'(0);
                    r_out_valid <= 1'b0;
                end
            end
            // A new read may start the next packet in the same cycle the
            // previous one transfers; it overrides the cleared counters.
            if (i_issue) begin
                r_issued <= w_issued_nxt;
                r_seal   <= i_last_in_row | (w_issued_nxt == CNT_W'(PACK));
                r_row    <= i_row_tag;
                r_col    <= i_col_tag;
            end
        end
    end

endmodule

// File: rtl/ipsum_noc_controller.sv
// ipsum_noc_controller
// Transmit-side NoC controller for input psums. Walks (n, m, e, F) with F
// fastest, reads 16-bit ipsums from the GLB at
//   addr = ((idx4*m + idx3)*e + idx2)*F + idx1
// and hands them to psum_packer, which builds PACK-lane GON words tagged with
// row (idx2) and col (idx3 mod t, restarting at each new batch).
// Ports: clk, reset (async active-low), start, done, F, m, n, e, t,
//   addr, re_to_glb, din (GLB read, data one cycle after re_to_glb),
//   we_to_gon_fifo, dout, gon_fifo_full, row_tag, col_tag (GON FIFO side).
// Optional build macro IPSUM_ZERO_INIT_EN adds input zero_init: when sampled
// high with start, no GLB reads are made and every lane is filled with zero.
module ipsum_noc_controller
    import ipsum_noc_pkg::*;
#(
    parameter int F_WIDTH       = 6,
    parameter int m_WIDTH       = 10,
    parameter int n_WIDTH       = 3,
    parameter int e_WIDTH       = 8,
    parameter int t_WIDTH       = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int PACK          = PACK_DEF,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int ADDR_WIDTH    = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
`ifdef IPSUM_ZERO_INIT_EN
    input  logic                          zero_init,
`endif
    output logic                          done,
    input  logic [F_WIDTH-1:0]            F,
    input  logic [m_WIDTH-1:0]            m,
    input  logic [n_WIDTH-1:0]            n,
    input  logic [e_WIDTH-1:0]            e,
    input  logic [t_WIDTH-1:0]            t,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic                          re_to_glb,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          we_to_gon_fifo,
    output logic [PACK*DATA_WIDTH-1:0]    dout,
    input  logic                          gon_fifo_full,
    output logic [ROW_TAG_WIDTH-1:0]      row_tag,
    output logic [COL_TAG_WIDTH-1:0]      col_tag
);

    localparam int AW = ADDR_WIDTH;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [F_WIDTH-1:0]       r_F;
    logic [m_WIDTH-1:0]       r_m;
    logic [n_WIDTH-1:0]       r_n;
    logic [e_WIDTH-1:0]       r_e;
    logic [t_WIDTH-1:0]       r_t;
    logic [F_WIDTH-1:0]       r_idx1;
    logic [e_WIDTH-1:0]       r_idx2;
    logic [m_WIDTH-1:0]       r_idx3;
    logic [n_WIDTH-1:0]       r_idx4;
    logic [COL_TAG_WIDTH-1:0] r_ctag;

    logic                     w_issue;
    logic                     w_can_issue;
    logic                     w_drained;
    logic                     w_cfg_zero;
    logic                     w_l1;
    logic                     w_l2;
    logic                     w_l3;
    logic                     w_l4;
    logic                     w_last;
    logic                     w_zero;
    logic [DATA_WIDTH-1:0]    w_din;

`ifdef IPSUM_ZERO_INIT_EN
    logic r_zero;
    assign w_zero = r_zero;
`else
    assign w_zero = 1'b0;
`endif

    assign w_cfg_zero = (F == F_WIDTH'(0)) | (m == m_WIDTH'(0)) | (n == n_WIDTH'(0)) |
                        (e == e_WIDTH'(0)) | (t == t_WIDTH'(0));
    assign w_l1   = (r_idx1 == r_F - F_WIDTH'(1));
    assign w_l2   = (r_idx2 == r_e - e_WIDTH'(1));
    assign w_l3   = (r_idx3 == r_m - m_WIDTH'(1));
    assign w_l4   = (r_idx4 == r_n - n_WIDTH'(1));
    assign w_last = w_l1 & w_l2 & w_l3 & w_l4;

    // Evaluating in ADDR_WIDTH arithmetic yields exactly the low bits of the
    // full-width result, since + and * are closed modulo 2**ADDR_WIDTH.
    assign addr = ((AW'(r_idx4) * AW'(r_m) + AW'(r_idx3)) * AW'(r_e) + AW'(r_idx2)) * AW'(r_F)
                  + AW'(r_idx1);

    assign re_to_glb = w_issue & ~w_zero;
    assign w_din     = w_zero ? DATA_WIDTH'(0) : din;
    assign done      = (r_state == DONE);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and read issue.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_zero ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_issue = w_can_issue;
                if (w_can_issue && w_last) begin
                    w_state_nxt = FLUSH;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (w_drained) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = FLUSH;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Configuration latch, index walk and col-tag counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_F    <= F_WIDTH'(0);
            r_m    <= m_WIDTH'(0);
            r_n    <= n_WIDTH'(0);
            r_e    <= e_WIDTH'(0);
            r_t    <= t_WIDTH'(0);
            r_idx1 <= F_WIDTH'(0);
            r_idx2 <= e_WIDTH'(0);
            r_idx3 <= m_WIDTH'(0);
            r_idx4 <= n_WIDTH'(0);
            r_ctag <= COL_TAG_WIDTH'(0);
`ifdef IPSUM_ZERO_INIT_EN
            r_zero <= 1'b0;
`endif
        end else if ((r_state == IDLE) && start) begin
            r_F    <= F;
            r_m    <= m;
            r_n    <= n;
            r_e    <= e;
            r_t    <= t;
            r_idx1 <= F_WIDTH'(0);
            r_idx2 <= e_WIDTH'(0);
            r_idx3 <= m_WIDTH'(0);
            r_idx4 <= n_WIDTH'(0);
            r_ctag <= COL_TAG_WIDTH'(0);
`ifdef IPSUM_ZERO_INIT_EN
            r_zero <= zero_init;
`endif
        end else if (w_issue) begin
            if (!w_l1) begin
                r_idx1 <= r_idx1 + F_WIDTH'(1);
            end else begin
                r_idx1 <= F_WIDTH'(0);
                if (!w_l2) begin
                    r_idx2 <= r_idx2 + e_WIDTH'(1);
                end else begin
                    r_idx2 <= e_WIDTH'(0);
                    if (!w_l3) begin
                        r_idx3 <= r_idx3 + m_WIDTH'(1);
                        // Channel counter mod t.
                        if (r_ctag == COL_TAG_WIDTH'(r_t - t_WIDTH'(1))) begin
                            r_ctag <= COL_TAG_WIDTH'(0);
                        end else begin
                            r_ctag <= r_ctag + COL_TAG_WIDTH'(1);
                        end
                    end else begin
                        r_idx3 <= m_WIDTH'(0);
                        r_idx4 <= r_idx4 + n_WIDTH'(1);
                        r_ctag <= COL_TAG_WIDTH'(0);
                    end
                end
            end
        end
    end

    psum_packer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PACK          (PACK),
        .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
        .COL_TAG_WIDTH (COL_TAG_WIDTH)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .i_issue       (w_issue),
        .i_last_in_row (w_l1),
        .i_row_tag     (ROW_TAG_WIDTH'(r_idx2)),
        .i_col_tag     (r_ctag),
        .i_din         (w_din),
        .i_full        (gon_fifo_full),
        .o_can_issue   (w_can_issue),
        .o_drained     (w_drained),
        .o_we          (we_to_gon_fifo),
        .o_dout        (dout),
        .o_row_tag     (row_tag),
        .o_col_tag     (col_tag)
    );

endmodule
